spi_master_multi: RTL and testbench
===================================

// Module: spi_master_multi
// PURPOSE
//  - Parametrised SPI master replacing the fixed 8-bit Mode-0 master used by the IO subsystem.
//  - Supports all four SPI modes, MSB- or LSB-first order, runtime clock divider and NUM_CS chip selects with automatic CS framing.
//  - Sits between the memory-mapped IO register block and the external SPI pins (flash, SD card, Ethernet).
// PARAMETERS
//  - DATA_WIDTH  8   bits per transfer, >= 2
//  - NUM_CS      4   number of active-low chip-select outputs, >= 1
//  - DIV_WIDTH   8   width of clk_div; half SPI period = clk_div clk cycles (0 treated as 1)
// PORTS
//  - clk        in   1               system clock; the only clock
//  - reset      in   1               synchronous, active-high reset
//  - start      in   1               request transfer; honoured only in IDLE, ignored while busy
//  - tx_data    in   DATA_WIDTH      word to transmit, latched on accepted start
//  - cpol       in   1               SPI clock idle level, latched on start
//  - cpha       in   1               0: sample leading edge; 1: sample trailing edge; latched on start
//  - lsb_first  in   1               1: LSB shifted first, for both TX and RX; latched on start
//  - clk_div    in   DIV_WIDTH       half-period in clk cycles, latched on start
//  - cs_sel     in   $clog2(NUM_CS)  chip select index (width 1 when NUM_CS=1), latched on start
//  - cs_keep    in   1               1: leave CS asserted after done (burst); latched on start
//  - busy       out  1               high from the cycle after start is accepted until done
//  - done       out  1               one-cycle pulse at end of transfer
//  - rx_data    out  DATA_WIDTH      received word, valid when done is high, held until the next done
//  - spi_clk    out  1               SPI clock
//  - spi_mosi   out  1               master out
//  - spi_miso   in   1               master in
//  - spi_cs_n   out  NUM_CS          active-low chip selects
// BEHAVIOUR
//  - Reset values: busy=0, done=0, rx_data=0, spi_clk=0, spi_mosi=0, spi_cs_n=all 1. FSM goes to IDLE, held CS is released.
//  - Reset mid-transfer aborts the transfer immediately: no done pulse, and CS is deasserted the cycle after reset.
//  - State IDLE:
//    - spi_clk = latched cpol (0 after reset).
//    - On start at cycle T: latch all inputs. Go to SETUP at T+1: busy=1, spi_cs_n[cs_sel]=0.
//    - For cpha=0, the first data bit is on spi_mosi at T+1.
//    - If CS is already held from a previous burst, a start with a different cs_sel first deasserts the old CS at T+1.
//  - State SETUP: lasts D = max(clk_div,1) cycles. Then TRANSFER.
//  - State TRANSFER: 2*DATA_WIDTH spi_clk edges, spaced D cycles apart; the first edge occurs at T+1+D.
//    - cpha=0: sample MISO on leading edges; shift MOSI on trailing edges, except the final trailing edge.
//    - cpha=1: shift MOSI on leading edges (first bit at the first edge); sample MISO on trailing edges.
//  - State HOLD: D cycles with spi_clk=cpol. Then DONE.
//  - State DONE (cycle T+2+(2*DATA_WIDTH+1)*D):
//    - done=1, busy=0, rx_data updated.
//    - spi_cs_n deasserts unless cs_keep. Return to IDLE next cycle.
//  - Back-to-back: a start sampled in the DONE cycle is ignored. A start in the following IDLE cycle is accepted.
//  - spi_mosi holds its last bit after the transfer.
//  - cs_sel >= NUM_CS: no CS line is asserted, but the transfer still runs.
//  - Bit counter is $clog2(DATA_WIDTH)+1 bits wide. Divider counter is DIV_WIDTH bits and wraps to 0 at D-1.
// CONFIGURATION
//  - SPI_MASTER_LOOPBACK_EN defined:
//    - Adds input port loopback (1 bit, latched on start).
//    - When latched high, MISO sampling uses the internal spi_mosi instead of spi_miso, so rx_data == tx_data. External pins behave normally.
//  - SPI_MASTER_LOOPBACK_EN undefined: no loopback port; sampling always uses spi_miso.
// STRUCTURE
//  - Package spi_master_pkg:
//    - FSM state encoding: IDLE, SETUP, TRANSFER, HOLD, DONE.
//    - Mode constants SPI_MODE0..3 = {cpol,cpha}.
//  - Sub-module spi_clk_gen: divider counter plus edge counter. Outputs leading/trailing edge strobes, spi_clk level and last_edge.
//  - Top level holds the FSM, shift registers and CS logic.
// TESTING
//  - Mode 0, D=1, MSB, tx=0xA5, miso model returns 0x3C:
//    - done exactly 19 cycles after start, rx_data=0x3C, slave sees 0xA5.
//    - spi_cs_n[0] low for cycles T+1..T+18.
//  - Modes 1, 2, 3 with D=3, tx=0x81, lsb_first=1:
//    - Slave model for each mode decodes 0x81 LSB-first.
//    - Idle spi_clk equals cpol before and after the transfer.
//    - Each spi_clk edge is 3 clk cycles apart.
//  - Two starts with cs_keep=1, cs_sel=2, then cs_keep=0:
//    - spi_cs_n[2] stays low across both transfers, high after the second done.
//    - Other CS lines stay high throughout.
//  - Assert start during busy, and again in the DONE cycle: both ignored, exactly one done pulse.
//  - Assert reset at the 5th spi_clk edge: no done pulse; spi_cs_n all 1, busy 0, spi_clk 0 on the next cycle.
//  - With SPI_MASTER_LOOPBACK_EN, loopback=1, tx=0x5A, spi_miso tied 0: rx_data=0x5A.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types for the multi-mode SPI master.
// FSM encoding and the {cpol,cpha} mode constants.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD,
    DONE
  } spi_state_e;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: divider tick, leading/trailing edge strobes,
// bit counter and the spi_clk level register.
module spi_clk_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 cpol,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 count_en,
  input  logic                 edge_en,
  input  logic                 div_clr,
  output logic                 tick,
  output logic                 lead,
  output logic                 trail,
  output logic                 last_edge,
  output logic                 bits_done,
  output logic                 spi_clk
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;

  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_m1;
  logic [BW-1:0]        bit_cnt;
  logic                 phase;
  logic                 edge_s;

  assign div_m1    = div - DIV_WIDTH'(1);
  assign tick      = count_en && (div_cnt == div_m1);
  assign bits_done = (bit_cnt == BW'(DATA_WIDTH));
  assign edge_s    = tick && edge_en && !bits_done;
  assign lead      = edge_s && !phase;
  assign trail     = edge_s && phase;
  assign last_edge = trail && (bit_cnt == BW'(DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (load || div_clr || !count_en || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

  // phase=1 means the next edge is a trailing edge
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      phase   <= 1'b0;
      spi_clk <= 1'b0;
    end else if (load) begin
      bit_cnt <= '0;
      phase   <= 1'b0;
      spi_clk <= cpol;
    end else if (edge_s) begin
      phase   <= ~phase;
      spi_clk <= ~spi_clk;
      if (phase) bit_cnt <= bit_cnt + BW'(1);
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master: four modes, MSB/LSB order, runtime divider, NUM_CS selects.
// Optional SPI_MASTER_LOOPBACK_EN adds an internal MOSI->MISO loopback.
module spi_master_multi
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 4,
  parameter int DIV_WIDTH  = 8,
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic                  cs_keep,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic [NUM_CS-1:0]     spi_cs_n
);

  spi_state_e state, state_n;

  logic [1:0]            mode_q;
  logic                  lsb_q;
  logic                  keep_q;
  logic [DIV_WIDTH-1:0]  d_q;
  logic [CS_W-1:0]       cs_idx;
  logic                  cs_on;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;

  logic load, count_en, edge_en, div_clr;
  logic tick, lead, trail, last_edge, bits_done;
  logic shift_ev, sample_ev, miso_s;

  function automatic logic pick(
    input logic [DATA_WIDTH-1:0] w,
    input logic                  lsb
  );
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sh_out(
    input logic [DATA_WIDTH-1:0] w,
    input logic                  lsb
  );
    return lsb ? {1'b0, w[DATA_WIDTH-1:1]}
               : {w[DATA_WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sh_in(
    input logic [DATA_WIDTH-1:0] w,
    input logic                  b,
    input logic                  lsb
  );
    return lsb ? {b, w[DATA_WIDTH-1:1]}
               : {w[DATA_WIDTH-2:0], b};
  endfunction

  assign load     = (state == IDLE) && start;
  assign count_en = (state == SETUP) || (state == TRANSFER)
                 || (state == HOLD);
  assign edge_en  = (state == SETUP) || (state == TRANSFER);
  // restart the divider so HOLD lasts a full D cycles
  assign div_clr  = (state == TRANSFER) && bits_done;
  assign busy     = count_en;
  assign done     = (state == DONE);

`ifdef SPI_MASTER_LOOPBACK_EN
  logic lb_q;

  always_ff @(posedge clk) begin
    if (reset)     lb_q <= 1'b0;
    else if (load) lb_q <= loopback;
  end

  assign miso_s = lb_q ? spi_mosi : spi_miso;
`else
  assign miso_s = spi_miso;
`endif

  spi_clk_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIV_WIDTH  (DIV_WIDTH)
  ) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .cpol      (cpol),
    .div       (d_q),
    .count_en  (count_en),
    .edge_en   (edge_en),
    .div_clr   (div_clr),
    .tick      (tick),
    .lead      (lead),
    .trail     (trail),
    .last_edge (last_edge),
    .bits_done (bits_done),
    .spi_clk   (spi_clk)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (start)     state_n = SETUP;
      SETUP:    if (lead)      state_n = TRANSFER;
      TRANSFER: if (bits_done) state_n = HOLD;
      HOLD:     if (tick)      state_n = DONE;
      DONE:                    state_n = IDLE;
      default:                 state_n = IDLE;
    endcase
  end

  always_comb begin
    shift_ev  = 1'b0;
    sample_ev = 1'b0;
    unique case (mode_q)
      SPI_MODE0, SPI_MODE2: begin
        shift_ev  = trail && !last_edge;
        sample_ev = lead;
      end
      SPI_MODE1, SPI_MODE3: begin
        shift_ev  = lead;
        sample_ev = trail;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= SPI_MODE0;
      lsb_q    <= 1'b0;
      keep_q   <= 1'b0;
      d_q      <= DIV_WIDTH'(1);
      cs_idx   <= '0;
      cs_on    <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      spi_mosi <= 1'b0;
    end else begin
      if (load) begin
        mode_q <= {cpol, cpha};
        lsb_q  <= lsb_first;
        keep_q <= cs_keep;
        d_q    <= (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;
        cs_idx <= cs_sel;
        cs_on  <= 1'b1;
        rx_sh  <= '0;
        // cpha=0 puts the first bit out before the first edge
        if (!cpha) begin
          spi_mosi <= pick(tx_data, lsb_first);
          tx_sh    <= sh_out(tx_data, lsb_first);
        end else begin
          tx_sh    <= tx_data;
        end
      end
      if (shift_ev) begin
        spi_mosi <= pick(tx_sh, lsb_q);
        tx_sh    <= sh_out(tx_sh, lsb_q);
      end
      if (sample_ev) begin
        rx_sh <= sh_in(rx_sh, miso_s, lsb_q);
      end
      if ((state == HOLD) && tick) begin
        rx_data <= rx_sh;
        if (!keep_q) cs_on <= 1'b0;
      end
    end
  end

  always_comb begin
    spi_cs_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_on && (cs_idx == CS_W'(i))) spi_cs_n[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi with a mode-aware SPI slave model.
// Loopback scenario is built only with SPI_MASTER_LOOPBACK_EN.
module tb_spi_master_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] tx_data;
  logic       cpol, cpha, lsb_first;
  logic [7:0] clk_div;
  logic [1:0] cs_sel;
  logic       cs_keep;
  logic       busy, done;
  logic [7:0] rx_data;
  logic       spi_clk, spi_mosi, spi_miso;
  logic [3:0] spi_cs_n;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic       loopback;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // slave model configuration (written by tasks only)
  logic [7:0] s_word;
  logic       s_cpol, s_cpha, s_lsb;
  logic [1:0] s_sel;
  logic       miso_zero;
  // slave model state (written by slave process only)
  logic [7:0] s_sh, s_rx;
  logic       s_miso, s_prev;

  always #5 clk = ~clk;

  assign spi_miso = miso_zero ? 1'b0 : s_miso;

  spi_master_multi dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .tx_data   (tx_data),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .clk_div   (clk_div),
    .cs_sel    (cs_sel),
    .cs_keep   (cs_keep),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback  (loopback),
`endif
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .spi_cs_n  (spi_cs_n)
  );

  initial begin
    s_sh = 8'h00; s_rx = 8'h00; s_miso = 1'b0; s_prev = 1'b0;
  end

  always @(negedge clk) begin
    logic lead_e;
    if (start && !busy) begin
      s_sh = s_word;
      s_rx = 8'h00;
      s_prev = s_cpol;
      if (!s_cpha) begin
        s_miso = s_lsb ? s_sh[0] : s_sh[7];
        s_sh = s_lsb ? (s_sh >> 1) : (s_sh << 1);
      end
    end else if (spi_cs_n[s_sel] == 1'b0 && spi_clk !== s_prev) begin
      lead_e = (s_prev == s_cpol);
      if (lead_e ^ s_cpha) begin
        s_rx = s_lsb ? {spi_mosi, s_rx[7:1]} : {s_rx[6:0], spi_mosi};
      end else begin
        s_miso = s_lsb ? s_sh[0] : s_sh[7];
        s_sh = s_lsb ? (s_sh >> 1) : (s_sh << 1);
      end
      s_prev = spi_clk;
    end
  end

  task automatic do_xfer(
    input  logic [7:0] tx, input logic [7:0] sw,
    input  logic pol, input logic pha, input logic lsb,
    input  logic [7:0] div, input logic [1:0] sel, input logic keep,
    output int cyc, output int nedge, output int first_e,
    output int gmin, output int gmax,
    output logic cs_ok, output logic oth_ok,
    output logic [3:0] cs_pre, output logic clk1, output logic mosi1
  );
    int last_e;
    logic pc;
    @(posedge clk); #1;
    cs_pre = spi_cs_n;
    tx_data = tx; cpol = pol; cpha = pha; lsb_first = lsb;
    clk_div = div; cs_sel = sel; cs_keep = keep;
    s_word = sw; s_cpol = pol; s_cpha = pha; s_lsb = lsb; s_sel = sel;
    start = 1'b1;
    cyc = 0; nedge = 0; first_e = 0; gmin = 1000; gmax = 0;
    cs_ok = 1'b1; oth_ok = 1'b1; last_e = 0; pc = 1'b0;
    clk1 = 1'b0; mosi1 = 1'b0;
    while (cyc < 400) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (cyc == 1) begin
        clk1 = spi_clk; mosi1 = spi_mosi; pc = spi_clk;
      end else if (spi_clk !== pc) begin
        nedge++;
        if (nedge == 1) first_e = cyc;
        else begin
          if (cyc - last_e < gmin) gmin = cyc - last_e;
          if (cyc - last_e > gmax) gmax = cyc - last_e;
        end
        last_e = cyc;
        pc = spi_clk;
      end
      for (int i = 0; i < 4; i++)
        if (i != int'(sel) && spi_cs_n[i] !== 1'b1) oth_ok = 1'b0;
      if (done === 1'b1) break;
      if (spi_cs_n[sel] !== 1'b0) cs_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0;
    tx_data = 8'h00; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    clk_div = 8'd1; cs_sel = 2'd0; cs_keep = 1'b0;
    s_word = 8'h00; s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0;
    s_sel = 2'd0; miso_zero = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++;
      $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++;
      $display("FAIL reset_rx got %h want 00", rx_data); end
    n_checks++; if (spi_clk !== 1'b0) begin n_fail++;
      $display("FAIL reset_sclk got %b want 0", spi_clk); end
    n_checks++; if (spi_mosi !== 1'b0) begin n_fail++;
      $display("FAIL reset_mosi got %b want 0", spi_mosi); end
    n_checks++; if (spi_cs_n !== 4'hF) begin n_fail++;
      $display("FAIL reset_cs got %h want f", spi_cs_n); end
  endtask

  task automatic test_mode0;
    int cyc, ne, fe, gmin, gmax;
    logic csok, othok, c1, m1;
    logic [3:0] cpre;
    do_xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 1'b0,
            cyc, ne, fe, gmin, gmax, csok, othok, cpre, c1, m1);
    n_checks++; if (cyc != 19) begin n_fail++;
      $display("FAIL m0_latency got %0d want 19", cyc); end
    n_checks++; if (rx_data !== 8'h3C) begin n_fail++;
      $display("FAIL m0_rx got %h want 3c", rx_data); end
    n_checks++; if (s_rx !== 8'hA5) begin n_fail++;
      $display("FAIL m0_slave got %h want a5", s_rx); end
    n_checks++; if (csok !== 1'b1 || othok !== 1'b1) begin n_fail++;
      $display("FAIL m0_cs_frame got %b%b want 11", csok, othok); end
    n_checks++; if (spi_cs_n !== 4'hF) begin n_fail++;
      $display("FAIL m0_cs_done got %h want f", spi_cs_n); end
    n_checks++; if (m1 !== 1'b1) begin n_fail++;
      $display("FAIL m0_first_mosi got %b want 1", m1); end
    n_checks++; if (ne != 16 || fe != 2) begin n_fail++;
      $display("FAIL m0_edges got %0d@%0d want 16@2", ne, fe); end
    n_checks++; if (busy !== 1'b0 || spi_mosi !== 1'b1) begin n_fail++;
      $display("FAIL m0_end got busy=%b mosi=%b want 0 1", busy, spi_mosi); end
  endtask

  task automatic test_modes;
    int cyc, ne, fe, gmin, gmax;
    logic csok, othok, c1, m1;
    logic [3:0] cpre;
    logic [1:0] m;
    for (int k = 1; k <= 3; k++) begin
      m = 2'(k);
      do_xfer(8'h81, 8'h6C, m[1], m[0], 1'b1, 8'd3, 2'd1, 1'b0,
              cyc, ne, fe, gmin, gmax, csok, othok, cpre, c1, m1);
      n_checks++; if (cyc != 53) begin n_fail++;
        $display("FAIL mode%0d_latency got %0d want 53", k, cyc); end
      n_checks++; if (ne != 16 || fe != 4) begin n_fail++;
        $display("FAIL mode%0d_edges got %0d@%0d want 16@4", k, ne, fe); end
      n_checks++; if (gmin != 3 || gmax != 3) begin n_fail++;
        $display("FAIL mode%0d_gap got %0d..%0d want 3..3", k, gmin, gmax); end
      n_checks++; if (c1 !== m[1] || spi_clk !== m[1]) begin n_fail++;
        $display("FAIL mode%0d_idle got %b/%b want %b", k, c1, spi_clk, m[1]); end
      n_checks++; if (rx_data !== 8'h6C) begin n_fail++;
        $display("FAIL mode%0d_rx got %h want 6c", k, rx_data); end
      n_checks++; if (s_rx !== 8'h81) begin n_fail++;
        $display("FAIL mode%0d_slave got %h want 81", k, s_rx); end
      n_checks++; if (csok !== 1'b1 || othok !== 1'b1) begin n_fail++;
        $display("FAIL mode%0d_cs got %b%b want 11", k, csok, othok); end
    end
  endtask

  task automatic test_burst;
    int cyc, ne, fe, gmin, gmax;
    logic csok, othok, c1, m1;
    logic [3:0] cpre;
    do_xfer(8'h11, 8'hE7, 1'b0, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1,
            cyc, ne, fe, gmin, gmax, csok, othok, cpre, c1, m1);
    n_checks++; if (spi_cs_n !== 4'b1011) begin n_fail++;
      $display("FAIL burst1_cs_done got %b want 1011", spi_cs_n); end
    n_checks++; if (rx_data !== 8'hE7 || csok !== 1'b1 || othok !== 1'b1) begin
      n_fail++;
      $display("FAIL burst1 got rx=%h cs=%b%b want e7 11", rx_data, csok, othok); end
    do_xfer(8'h22, 8'h5D, 1'b0, 1'b0, 1'b0, 8'd1, 2'd2, 1'b0,
            cyc, ne, fe, gmin, gmax, csok, othok, cpre, c1, m1);
    n_checks++; if (cpre !== 4'b1011) begin n_fail++;
      $display("FAIL burst_gap_cs got %b want 1011", cpre); end
    n_checks++; if (cyc != 19 || csok !== 1'b1 || othok !== 1'b1) begin n_fail++;
      $display("FAIL burst2 got cyc=%0d cs=%b%b want 19 11", cyc, csok, othok); end
    n_checks++; if (rx_data !== 8'h5D || s_rx !== 8'h22) begin n_fail++;
      $display("FAIL burst2_data got %h/%h want 5d/22", rx_data, s_rx); end
    n_checks++; if (spi_cs_n !== 4'hF) begin n_fail++;
      $display("FAIL burst2_cs_done got %h want f", spi_cs_n); end
  endtask

  task automatic test_ignore_start;
    int dones, done_at;
    logic [7:0] srx_at;
    @(posedge clk); #1;
    tx_data = 8'hC3; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    clk_div = 8'd2; cs_sel = 2'd3; cs_keep = 1'b0;
    s_word = 8'h96; s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0; s_sel = 2'd3;
    start = 1'b1;
    dones = 0; done_at = 0; srx_at = 8'h00;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc == 5) begin start = 1'b1; tx_data = 8'h00; end
      if (done === 1'b1) begin
        dones++;
        if (done_at == 0) begin done_at = cyc; srx_at = s_rx; start = 1'b1; end
      end
    end
    start = 1'b0;
    n_checks++; if (dones != 1) begin n_fail++;
      $display("FAIL ign_done_count got %0d want 1", dones); end
    n_checks++; if (done_at != 36) begin n_fail++;
      $display("FAIL ign_latency got %0d want 36", done_at); end
    n_checks++; if (rx_data !== 8'h96 || srx_at !== 8'hC3) begin n_fail++;
      $display("FAIL ign_data got %h/%h want 96/c3", rx_data, srx_at); end
    n_checks++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL ign_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_div_zero;
    int cyc, ne, fe, gmin, gmax;
    logic csok, othok, c1, m1;
    logic [3:0] cpre;
    do_xfer(8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0,
            cyc, ne, fe, gmin, gmax, csok, othok, cpre, c1, m1);
    n_checks++; if (cyc != 19 || gmax != 1) begin n_fail++;
      $display("FAIL div0 got cyc=%0d gap=%0d want 19 1", cyc, gmax); end
    n_checks++; if (rx_data !== 8'hF0) begin n_fail++;
      $display("FAIL div0_rx got %h want f0", rx_data); end
  endtask

  task automatic test_reset_abort;
    int ne, dones, cyc;
    logic pc;
    @(posedge clk); #1;
    tx_data = 8'h77; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0;
    clk_div = 8'd2; cs_sel = 2'd1; cs_keep = 1'b1;
    s_word = 8'h00; s_cpol = 1'b1; s_cpha = 1'b0; s_lsb = 1'b0; s_sel = 2'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pc = spi_clk; ne = 0; cyc = 0;
    while (ne < 5 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (spi_clk !== pc) begin ne++; pc = spi_clk; end
    end
    n_checks++; if (ne != 5) begin n_fail++;
      $display("FAIL abort_reach_edge5 got %0d want 5", ne); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (spi_cs_n !== 4'hF || busy !== 1'b0) begin n_fail++;
      $display("FAIL abort_cs_busy got %h/%b want f/0", spi_cs_n, busy); end
    n_checks++; if (spi_clk !== 1'b0 || done !== 1'b0) begin n_fail++;
      $display("FAIL abort_sclk_done got %b/%b want 0/0", spi_clk, done); end
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    n_checks++; if (dones != 0 || spi_cs_n !== 4'hF) begin n_fail++;
      $display("FAIL abort_after got dones=%0d cs=%h want 0 f", dones, spi_cs_n); end
  endtask

`ifdef SPI_MASTER_LOOPBACK_EN
  task automatic test_loopback;
    int cyc, ne, fe, gmin, gmax;
    logic csok, othok, c1, m1;
    logic [3:0] cpre;
    miso_zero = 1'b1; loopback = 1'b1;
    do_xfer(8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 1'b0,
            cyc, ne, fe, gmin, gmax, csok, othok, cpre, c1, m1);
    n_checks++; if (rx_data !== 8'h5A) begin n_fail++;
      $display("FAIL loopback_rx got %h want 5a", rx_data); end
    n_checks++; if (s_rx !== 8'h5A) begin n_fail++;
      $display("FAIL loopback_pins got %h want 5a", s_rx); end
    miso_zero = 1'b0; loopback = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_burst();
    test_ignore_start();
    test_div_zero();
    test_reset_abort();
`ifdef SPI_MASTER_LOOPBACK_EN
    test_loopback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
